// File: rtl/matrix_loader_pkg.sv
// rtl/matrix_loader_pkg.sv - shared sizes and FSM encoding for matrix_loader
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package matrix_loader_pkg;
  localparam int N     = 4;
  localparam int M     = 3;
  localparam int L     = 8;
  localparam int K     = 16;
  localparam int W     = `CLOG2(M);
  localparam int NW    = N * W;
  localparam int KB    = K / N;
  localparam int WORDS = L * K / N;
  localparam int AW    = `CLOG2(WORDS);
  localparam int SBW   = `CLOG2(KB + 1);
  localparam int EW    = (N > 1) ? `CLOG2(N) : 1;
  localparam int BW    = (KB > 1) ? `CLOG2(KB) : 1;
  localparam int RW    = (L > 1) ? `CLOG2(L) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, KICK, WAIT} state_t;
endpackage

// File: rtl/matrix_loader_elem_packer.sv
// rtl/matrix_loader_elem_packer.sv - shifts W-bit elements into an N*W word, slot 0 in the low bits
module matrix_loader_elem_packer
  import matrix_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic          last_slot,
  input  logic [W-1:0]  elem_data,
  output logic [NW-1:0] word,
  output logic          word_valid
);

  logic [NW-1:0] shift_q;
  logic [NW-1:0] shift_next;

  // New elements enter at the top so the first element of a word ends up in slot 0
  assign shift_next = {elem_data, shift_q[NW-1:W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && last_slot;
      if (accept) begin
        shift_q <= shift_next;
        if (last_slot) begin
          word <= shift_next;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - loads an LxK GF(M) matrix into the phase buffer and runs phase once
// Optional RANGE_CHECK_EN: out-of-field elements fail the load instead of starting phase.
module matrix_loader
  import matrix_loader_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load_start,
  input  logic           last_phase,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic [NW-1:0]  data_out,
  output logic           phase_start,
  output logic [SBW-1:0] start_block,
  output logic           phase_last,
  input  logic           phase_done,
  input  logic           phase_fail,
  output logic           busy,
  output logic           done,
  output logic           fail
);

  state_t        state;
  state_t        state_next;
  logic [EW-1:0] elem;
  logic [BW-1:0] blk;
  logic [RW-1:0] row;
  logic [AW-1:0] next_addr;
  logic          accept;
  logic          last_slot;
  logic          blk_last;
  logic          row_last;
  logic          last_accept;
  logic          load_go;
  logic          done_next;
  logic          fail_next;
  logic          range_err;

  assign in_ready    = (state == LOAD);
  assign accept      = in_valid && in_ready;
  assign load_go     = (state == IDLE) && load_start;
  assign last_slot   = (elem == EW'(N - 1));
  assign blk_last    = (blk == BW'(KB - 1));
  assign row_last    = (row == RW'(L - 1));
  assign last_accept = accept && last_slot && blk_last && row_last;
  assign phase_start = (state == KICK);
  assign busy        = (state != IDLE);
  assign start_block = '0;

  matrix_loader_elem_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .last_slot  (last_slot),
    .elem_data  (in_data),
    .word       (data_out),
    .word_valid (wr_en)
  );

  // next_addr steps by L across column blocks and restarts at row+1 when a row ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem       <= '0;
      blk        <= '0;
      row        <= '0;
      next_addr  <= '0;
      wr_addr    <= '0;
      phase_last <= 1'b0;
    end else if (load_go) begin
      elem       <= '0;
      blk        <= '0;
      row        <= '0;
      next_addr  <= '0;
      phase_last <= last_phase;
    end else if (accept) begin
      elem <= last_slot ? '0 : elem + EW'(1);
      if (last_slot) begin
        wr_addr <= next_addr;
        if (blk_last) begin
          blk       <= '0;
          row       <= row_last ? '0 : row + RW'(1);
          next_addr <= AW'(row) + AW'(1);
        end else begin
          blk       <= blk + BW'(1);
          next_addr <= next_addr + AW'(L);
        end
      end
    end
  end

`ifdef RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      range_err <= 1'b0;
    end else if (load_go) begin
      range_err <= 1'b0;
    end else if (accept && (int'(in_data) >= M)) begin
      range_err <= 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    fail_next  = 1'b0;
    case (state)
      IDLE:  if (load_start) state_next = LOAD;
      LOAD:  if (last_accept) state_next = FLUSH;
      FLUSH: begin
        if (range_err) begin
          fail_next  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = KICK;
        end
      end
      KICK:  state_next = WAIT;
      WAIT: begin
        if (phase_fail) begin
          fail_next  = 1'b1;
          state_next = IDLE;
        end else if (phase_done) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      fail  <= fail_next;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader
`timescale 1ns/1ps
module tb_matrix_loader;
  import matrix_loader_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           load_start = 1'b0;
  logic           last_phase = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           phase_done = 1'b0;
  logic           phase_fail = 1'b0;
  logic           in_ready, wr_en, phase_start, phase_last, busy, done, fail;
  logic [AW-1:0]  wr_addr;
  logic [NW-1:0]  data_out;
  logic [SBW-1:0] start_block;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [NW-1:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] evq[$];
  wr_t        popped;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_wr_cyc = -10;
  int         wr_cnt = 0;
  int         kicks = 0;
  bit         expect_kick = 1'b0;
  logic [AW-1:0] first_addr, second_addr, last_addr;
  logic [NW-1:0] first_data, second_data;

  always #5 clk = ~clk;

  matrix_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .last_phase  (last_phase),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .data_out    (data_out),
    .phase_start (phase_start),
    .start_block (start_block),
    .phase_last  (phase_last),
    .phase_done  (phase_done),
    .phase_fail  (phase_fail),
    .busy        (busy),
    .done        (done),
    .fail        (fail)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write and every done/fail pulse
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (wr_en) begin
        chk("scoreboard has word for wr_en", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          popped = wq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(popped.addr));
          chk("data_out", 32'(data_out), 32'(popped.data));
        end
        if (wr_cnt == 0) begin
          first_addr = wr_addr;
          first_data = data_out;
        end
        if (wr_cnt == 1) begin
          second_addr = wr_addr;
          second_data = data_out;
        end
        last_addr   = wr_addr;
        last_wr_cyc = cyc;
        wr_cnt++;
      end
      if (phase_start) begin
        chk("phase_start expected", 32'(expect_kick), 1);
        chk("phase_start one cycle after last wr_en", cyc - last_wr_cyc, 1);
        chk("writes before phase_start", wr_cnt, WORDS);
        chk("start_block", 32'(start_block), 0);
        chk("wr_en with phase_start", 32'(wr_en), 0);
        expect_kick = 1'b0;
        kicks++;
      end
      if (done || fail) begin
        chk("done/fail event expected", 32'(evq.size() > 0), 1);
        if (evq.size() > 0) chk("done/fail", 32'({fail, done}), 32'(evq.pop_front()));
        chk("busy at done/fail", 32'(busy), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic lp);
    load_start = 1'b1;
    last_phase = lp;
    wr_cnt     = 0;
    tick();
    load_start = 1'b0;
    last_phase = 1'b0;
    chk("in_ready after load_start", 32'(in_ready), 1);
    chk("busy after load_start", 32'(busy), 1);
    chk("phase_last captured", 32'(phase_last), 32'(lp));
  endtask

  task automatic stream(input int n_elems, input bit gaps, input bit bad, input bit poke);
    logic [NW-1:0] cur_word;
    logic [W-1:0]  v;
    wr_t           e;
    int            r, c, guard;
    bit            acc;
    cur_word = '0;
    for (int i = 0; i < n_elems; i++) begin
      r = i / K;
      c = i % K;
      v = (bad && r == 2 && c == 5) ? W'(3) : W'((r + c) % M);
      cur_word[(c % N) * W +: W] = v;
      if (c % N == N - 1) begin
        e.addr = AW'((c / N) * L + r);
        e.data = cur_word;
        wq.push_back(e);
      end
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        in_valid   = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        in_data    = v;
        load_start = poke && (i == 20);
        @(negedge clk);
        acc = in_valid && in_ready;
        tick();
        guard++;
        if (!acc && guard > 50) begin
          chk("element accepted within budget", 32'(acc), 1);
          in_valid   = 1'b0;
          load_start = 1'b0;
          return;
        end
      end
      load_start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_events();
    int g = 0;
    while (evq.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("pending done/fail events", evq.size(), 0);
    chk("pending writes", wq.size(), 0);
    @(negedge clk);
    chk("busy when idle", 32'(busy), 0);
    chk("in_ready when idle", 32'(in_ready), 0);
  endtask

  task automatic finish_phase(input bit pdone, input bit pfail);
    int guard = 0;
    while (!phase_start && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("phase_start seen", 32'(phase_start), 1);
    tick();
    phase_done = pdone;
    phase_fail = pfail;
    evq.push_back(pfail ? 2'b10 : 2'b01);
    tick();
    phase_done = 1'b0;
    phase_fail = 1'b0;
  endtask

  task automatic run_full(input bit lp, input bit gaps, input bit poke, input bit pdone, input bit pfail);
    chk("in_ready before load", 32'(in_ready), 0);
    expect_kick = 1'b1;
    start_load(lp);
    stream(L * K, gaps, 1'b0, poke);
    @(negedge clk);
    chk("in_ready in flush", 32'(in_ready), 0);
    finish_phase(pdone, pfail);
    wait_events();
    chk("wr_en count", wr_cnt, WORDS);
    chk("first word addr", 32'(first_addr), 0);
    chk("first word data", 32'(first_data), 32'h24);
    chk("second word addr", 32'(second_addr), 8);
    chk("second word data", 32'(second_data), 32'h49);
    chk("last word addr", 32'(last_addr), 31);
    chk("phase_last held", 32'(phase_last), 32'(lp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_kicks;
    exp_kicks = 0;
    rst = 1'b0;
    repeat (3) tick();
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset wr_en", 32'(wr_en), 0);
    chk("reset wr_addr", 32'(wr_addr), 0);
    chk("reset data_out", 32'(data_out), 0);
    chk("reset phase_start", 32'(phase_start), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset fail", 32'(fail), 0);
    rst = 1'b1;
    tick();

    run_full(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_kicks++;
    run_full(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_kicks++;
    run_full(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_kicks++;
    run_full(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_kicks++;

    start_load(1'b1);
    stream(37, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("async reset in_ready", 32'(in_ready), 0);
    chk("async reset wr_en", 32'(wr_en), 0);
    chk("async reset wr_addr", 32'(wr_addr), 0);
    chk("async reset data_out", 32'(data_out), 0);
    chk("async reset phase_start", 32'(phase_start), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset phase_last", 32'(phase_last), 0);
    chk("words written before reset", wr_cnt, 9);
    chk("pending writes at reset", wq.size(), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run_full(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_kicks++;

`ifdef RANGE_CHECK_EN
    chk("in_ready before bad load", 32'(in_ready), 0);
    expect_kick = 1'b0;
    evq.push_back(2'b10);
    start_load(1'b0);
    stream(L * K, 1'b0, 1'b1, 1'b0);
    wait_events();
    chk("bad load wr_en count", wr_cnt, WORDS);
    run_full(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_kicks++;
`endif

    chk("phase_start count", kicks, exp_kicks);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
